vexec_unit: RTL and testbench

VEXEC_UNIT -- requirements
Module: vexec_unit

---
 rtl/vrvv_pkg.sv | 63 ++++++
 rtl/vexec_simd_alu.sv | 72 +++++++
 rtl/vexec_unit.sv | 152 +++++++++++++++
 tb/tb_vexec_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vrvv_pkg.sv
// ---------------------------------------------------------------------------
// vrvv_pkg -- shared vector definitions for the vector execute stage.
//   Opcode constants, SEW encodings, the execute FSM state type, and small
//   helpers that map an SEW code to element geometry (mask, element offset,
//   index of the last element in a 64-bit register).
// ---------------------------------------------------------------------------
package vrvv_pkg;

    localparam int VLEN_SUPPORTED = 64;

    // Vector opcodes. Codes 8-15 are unassigned and yield a zero,
    // non-writing result.
    localparam logic [3:0] VOP_ADD = 4'd0;
    localparam logic [3:0] VOP_SUB = 4'd1;
    localparam logic [3:0] VOP_AND = 4'd2;
    localparam logic [3:0] VOP_OR  = 4'd3;
    localparam logic [3:0] VOP_XOR = 4'd4;
    localparam logic [3:0] VOP_SLL = 4'd5;
    localparam logic [3:0] VOP_SRL = 4'd6;
    localparam logic [3:0] VOP_MUL = 4'd7;

    // Element width encodings.
    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;
    localparam logic [1:0] SEW_64 = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } vexec_state_e;

    // Index of the last element: (64/SEW)-1.
    function automatic logic [2:0] sew_last_idx(input logic [1:0] sew);
        case (sew)
            SEW_8:   sew_last_idx = 3'd7;
            SEW_16:  sew_last_idx = 3'd3;
            SEW_32:  sew_last_idx = 3'd1;
            default: sew_last_idx = 3'd0;
        endcase
    endfunction

    // Mask covering one element in the low bits.
    function automatic logic [63:0] sew_mask(input logic [1:0] sew);
        case (sew)
            SEW_8:   sew_mask = 64'h0000_0000_0000_00FF;
            SEW_16:  sew_mask = 64'h0000_0000_0000_FFFF;
            SEW_32:  sew_mask = 64'h0000_0000_FFFF_FFFF;
            default: sew_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Bit offset of element idx: idx * SEW.
    function automatic logic [5:0] elem_offset(input logic [1:0] sew, input logic [2:0] idx);
        case (sew)
            SEW_8:   elem_offset = {idx, 3'b000};
            SEW_16:  elem_offset = {idx[1:0], 4'b0000};
            SEW_32:  elem_offset = {idx[0], 5'b00000};
            default: elem_offset = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/vexec_simd_alu.sv
// ---------------------------------------------------------------------------
// vexec_simd_alu -- combinational element-wise vector ALU (single-cycle ops).
//   i_a, i_b  : 64-bit source vectors
//   i_vop     : opcode (add/sub/and/or/xor/sll/srl); anything else -> 0
//   i_vsew    : element width code
//   o_result  : per-element result, modulo 2^SEW, no cross-element carry
// ---------------------------------------------------------------------------
module vexec_simd_alu
    import vrvv_pkg::*;
(
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic [3:0]  i_vop,
    input  logic [1:0]  i_vsew,
    output logic [63:0] o_result
);

    logic [63:0] w_lane;

    // Operates on zero-extended elements; the caller keeps only the low SEW
    // bits, which discards carries/borrows and shifted-out bits. Zero
    // extension also makes srl a logical shift.
    function automatic logic [63:0] lane_op(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [3:0]  op,
        input logic [5:0]  shmask
    );
        logic [5:0] sh;
        sh = b[5:0] & shmask;
        case (op)
            VOP_ADD: lane_op = a + b;
            VOP_SUB: lane_op = a - b;
            VOP_AND: lane_op = a & b;
            VOP_OR:  lane_op = a | b;
            VOP_XOR: lane_op = a ^ b;
            VOP_SLL: lane_op = a << sh;
            VOP_SRL: lane_op = a >> sh;
            default: lane_op = 64'd0;
        endcase
    endfunction

    always_comb begin
        o_result = '0;
        w_lane   = '0;
        case (i_vsew)
            SEW_8: begin
                for (int i = 0; i < 8; i++) begin
                    w_lane = lane_op({56'd0, i_a[i*8 +: 8]}, {56'd0, i_b[i*8 +: 8]}, i_vop, 6'd7);
                    o_result[i*8 +: 8] = w_lane[7:0];
                end
            end
            SEW_16: begin
                for (int i = 0; i < 4; i++) begin
                    w_lane = lane_op({48'd0, i_a[i*16 +: 16]}, {48'd0, i_b[i*16 +: 16]}, i_vop, 6'd15);
                    o_result[i*16 +: 16] = w_lane[15:0];
                end
            end
            SEW_32: begin
                for (int i = 0; i < 2; i++) begin
                    w_lane = lane_op({32'd0, i_a[i*32 +: 32]}, {32'd0, i_b[i*32 +: 32]}, i_vop, 6'd31);
                    o_result[i*32 +: 32] = w_lane[31:0];
                end
            end
            default: begin
                w_lane   = lane_op(i_a, i_b, i_vop, 6'd63);
                o_result = w_lane;
            end
        endcase
    end

endmodule

// File: rtl/vexec_unit.sv
// ---------------------------------------------------------------------------
// vexec_unit -- vector execute stage with a multi-cycle element-serial vmul.
//   clock, reset          : single clock, synchronous active-high reset
//   IDEX_*                : instruction from the ID/EX register
//   bypassOutvA/B         : forwarded vector operands
//   vex_flush             : kills the in-flight instruction
//   vex_busy              : stall request to ID/EX
//   EXMEM_*               : EX/MEM pipeline register outputs
//   o_dbg_state           : current FSM state, for observation
//
// Handshake: an instruction is taken when IDEX_valid=1 in IDLE with no
// flush. While vex_busy=1 the IDEX inputs are ignored and upstream holds
// them; vex_busy drops in the final multiply cycle so ID/EX can advance on
// that edge and the next instruction is taken in the following IDLE cycle.
// EXMEM_valid pulses for exactly one cycle per completed instruction.
// ---------------------------------------------------------------------------
module vexec_unit
    import vrvv_pkg::*;
#(
    parameter int VLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            IDEX_valid,
    input  logic [3:0]      IDEX_vop,
    input  logic [1:0]      IDEX_vsew,
    input  logic [4:0]      IDEX_instr_vrd,
    input  logic            IDEX_vRegWrite,
    input  logic [VLEN-1:0] bypassOutvA,
    input  logic [VLEN-1:0] bypassOutvB,
    input  logic            vex_flush,
    output logic            vex_busy,
    output logic            EXMEM_valid,
    output logic [4:0]      EXMEM_instr_vrd,
    output logic            EXMEM_vRegWrite,
    output logic [VLEN-1:0] EXMEM_vALU_Out,
    output vexec_state_e    o_dbg_state
);

    vexec_state_e    r_state;
    vexec_state_e    w_next_state;
    logic [2:0]      r_cnt;
    logic [VLEN-1:0] r_a;
    logic [VLEN-1:0] r_b;
    logic [VLEN-1:0] r_acc;
    logic [4:0]      r_vrd;
    logic            r_vwe;
    logic [1:0]      r_sew;

    logic            w_last;
    logic            w_is_mul;
    logic            w_op_legal;
    logic [5:0]      w_off;
    logic [VLEN-1:0] w_mask;
    logic [VLEN-1:0] w_ea;
    logic [VLEN-1:0] w_eb;
    logic [VLEN-1:0] w_prod;
    logic [VLEN-1:0] w_acc_next;
    logic [VLEN-1:0] w_alu;

    vexec_simd_alu u_alu (
        .i_a      (bypassOutvA),
        .i_b      (bypassOutvB),
        .i_vop    (IDEX_vop),
        .i_vsew   (IDEX_vsew),
        .o_result (w_alu)
    );

    assign w_is_mul    = (IDEX_vop == VOP_MUL);
    assign w_op_legal  = !IDEX_vop[3];
    assign w_last      = (r_state == ST_MUL) && (r_cnt == sew_last_idx(r_sew));
    assign vex_busy    = !reset && (r_state == ST_MUL) && !w_last;
    assign o_dbg_state = r_state;

    // One element per cycle: extract element r_cnt, multiply, keep the low
    // SEW bits and merge into the accumulating result.
    assign w_off      = elem_offset(r_sew, r_cnt);
    assign w_mask     = sew_mask(r_sew);
    assign w_ea       = (r_a >> w_off) & w_mask;
    assign w_eb       = (r_b >> w_off) & w_mask;
    assign w_prod     = (w_ea * w_eb) & w_mask;
    assign w_acc_next = r_acc | (w_prod << w_off);

    always_comb begin
        w_next_state = r_state;
        if (vex_flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (IDEX_valid && w_is_mul) w_next_state = ST_MUL;
                ST_MUL:  if (w_last) w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt           <= '0;
            r_a             <= '0;
            r_b             <= '0;
            r_acc           <= '0;
            r_vrd           <= '0;
            r_vwe           <= 1'b0;
            r_sew           <= '0;
            EXMEM_valid     <= 1'b0;
            EXMEM_vRegWrite <= 1'b0;
            EXMEM_instr_vrd <= '0;
            EXMEM_vALU_Out  <= '0;
        end else begin
            // Bubble unless something completes below; vrd/result hold.
            EXMEM_valid     <= 1'b0;
            EXMEM_vRegWrite <= 1'b0;
            if (vex_flush) begin
                r_cnt <= '0;
            end else if (r_state == ST_IDLE) begin
                if (IDEX_valid) begin
                    if (w_is_mul) begin
                        r_a   <= bypassOutvA;
                        r_b   <= bypassOutvB;
                        r_vrd <= IDEX_instr_vrd;
                        r_vwe <= IDEX_vRegWrite;
                        r_sew <= IDEX_vsew;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end else begin
                        EXMEM_valid     <= 1'b1;
                        EXMEM_vRegWrite <= IDEX_vRegWrite && w_op_legal;
                        EXMEM_instr_vrd <= IDEX_instr_vrd;
                        EXMEM_vALU_Out  <= w_alu;
                    end
                end
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 3'd1;
                if (w_last) begin
                    r_cnt           <= '0;
                    EXMEM_valid     <= 1'b1;
                    EXMEM_vRegWrite <= r_vwe;
                    EXMEM_instr_vrd <= r_vrd;
                    EXMEM_vALU_Out  <= w_acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_vexec_unit.sv
// ---------------------------------------------------------------------------
// tb_vexec_unit -- self-checking bench for vexec_unit.
//   Reference model: a remaining-cycles counter for vmul plus a whole-vector
//   arithmetic reference; expected results also flow through exp_q.
// ---------------------------------------------------------------------------
module tb_vexec_unit;

    logic        clock;
    logic        reset;
    logic        IDEX_valid;
    logic [3:0]  IDEX_vop;
    logic [1:0]  IDEX_vsew;
    logic [4:0]  IDEX_instr_vrd;
    logic        IDEX_vRegWrite;
    logic [63:0] bypassOutvA;
    logic [63:0] bypassOutvB;
    logic        vex_flush;
    logic        vex_busy;
    logic        EXMEM_valid;
    logic [4:0]  EXMEM_instr_vrd;
    logic        EXMEM_vRegWrite;
    logic [63:0] EXMEM_vALU_Out;
    vrvv_pkg::vexec_state_e dbg_state;

    vexec_unit #(.VLEN(64)) dut (
        .clock           (clock),
        .reset           (reset),
        .IDEX_valid      (IDEX_valid),
        .IDEX_vop        (IDEX_vop),
        .IDEX_vsew       (IDEX_vsew),
        .IDEX_instr_vrd  (IDEX_instr_vrd),
        .IDEX_vRegWrite  (IDEX_vRegWrite),
        .bypassOutvA     (bypassOutvA),
        .bypassOutvB     (bypassOutvB),
        .vex_flush       (vex_flush),
        .vex_busy        (vex_busy),
        .EXMEM_valid     (EXMEM_valid),
        .EXMEM_instr_vrd (EXMEM_instr_vrd),
        .EXMEM_vRegWrite (EXMEM_vRegWrite),
        .EXMEM_vALU_Out  (EXMEM_vALU_Out),
        .o_dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          busy_seen = 0;
    int          valid_seen = 0;
    logic [63:0] exp_q[$];

    int          m_rem = 0;
    logic        m_valid = 1'b0;
    logic        m_vwe = 1'b0;
    logic [4:0]  m_vrd = '0;
    logic [63:0] m_res = '0;
    logic        p_vwe = 1'b0;
    logic [4:0]  p_vrd = '0;
    logic [63:0] p_res = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Whole-vector reference: split into 64/SEW elements, operate on each
    // with plain arithmetic, keep the low SEW bits.
    function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [1:0] sew,
                                           input logic [63:0] a, input logic [63:0] b);
        int          w;
        int          n;
        int          sh;
        logic [63:0] mask;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] r;
        logic [63:0] res;
        w    = 8 << sew;
        n    = 64 / w;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        res  = '0;
        for (int e = 0; e < n; e++) begin
            ea = (a >> (e * w)) & mask;
            eb = (b >> (e * w)) & mask;
            sh = int'(eb & 64'(w - 1));
            case (op)
                4'd0:    r = ea + eb;
                4'd1:    r = ea - eb;
                4'd2:    r = ea & eb;
                4'd3:    r = ea | eb;
                4'd4:    r = ea ^ eb;
                4'd5:    r = ea << sh;
                4'd6:    r = ea >> sh;
                4'd7:    r = ea * eb;
                default: r = '0;
            endcase
            res = res | ((r & mask) << (e * w));
        end
        return res;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input logic v, input logic [3:0] op, input logic [1:0] sew,
                        input logic [4:0] rd, input logic we, input logic [63:0] a,
                        input logic [63:0] b, input logic fl, input logic rst);
        reset          = rst;
        IDEX_valid     = v;
        IDEX_vop       = op;
        IDEX_vsew      = sew;
        IDEX_instr_vrd = rd;
        IDEX_vRegWrite = we;
        bypassOutvA    = a;
        bypassOutvB    = b;
        vex_flush      = fl;
        #1;
        check("busy", 64'(vex_busy), 64'(!rst && m_rem > 1));
        if (vex_busy) busy_seen++;
        @(posedge clock);
        m_valid = 1'b0;
        m_vwe   = 1'b0;
        if (rst) begin
            m_rem = 0;
            m_vrd = '0;
            m_res = '0;
            exp_q.delete();
        end else if (fl) begin
            m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_valid = 1'b1;
                m_vwe   = p_vwe;
                m_vrd   = p_vrd;
                m_res   = p_res;
            end
        end else if (v) begin
            if (op == 4'd7) begin
                m_rem = 64 / (8 << sew);
                p_vwe = we;
                p_vrd = rd;
                p_res = ref_op(op, sew, a, b);
            end else begin
                m_valid = 1'b1;
                m_vwe   = we && (op < 4'd8);
                m_vrd   = rd;
                m_res   = ref_op(op, sew, a, b);
            end
        end
        if (m_valid) exp_q.push_back(m_res);
        #1;
        check("valid", 64'(EXMEM_valid), 64'(m_valid));
        check("vwe", 64'(EXMEM_vRegWrite), 64'(m_vwe));
        check("vrd", 64'(EXMEM_instr_vrd), 64'(m_vrd));
        check("res", EXMEM_vALU_Out, m_res);
        if (EXMEM_valid) begin
            valid_seen++;
            if (exp_q.size() > 0) check("q_res", EXMEM_vALU_Out, exp_q.pop_front());
            else                  check("q_size", 64'(exp_q.size()), 64'd1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 2'd0, 5'd0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [3:0]  rop;

        // Reset state
        step(1'b1, 4'd7, 2'd0, 5'd3, 1'b1, '1, '1, 1'b1, 1'b1);
        step(1'b0, 4'd0, 2'd0, 5'd0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("rst_state", 64'(dbg_state), 64'(vrvv_pkg::ST_IDLE));
        idle(1);

        // vadd SEW=8 byte wrap, no carry into next byte
        step(1'b1, 4'd0, 2'd0, 5'd1, 1'b1, 64'h0000_0000_0000_00FF, 64'h1, 1'b0, 1'b0);
        check("d_vadd_res", EXMEM_vALU_Out, 64'h0);
        check("d_vadd_v", 64'(EXMEM_valid), 64'd1);
        idle(1);

        // vsub SEW=16 borrow confined to each element
        step(1'b1, 4'd1, 2'd1, 5'd2, 1'b1, 64'h0, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
        check("d_vsub_res", EXMEM_vALU_Out, 64'hFFFF_FFFF_FFFF_FFFF);

        // vmul SEW=8: 7 busy cycles, result after the 8th element cycle
        busy_seen = 0;
        step(1'b1, 4'd7, 2'd0, 5'd4, 1'b1, 64'h0807_0605_0403_0201, 64'h0202_0202_0202_0202, 1'b0, 1'b0);
        idle(8);
        check("d_mul8_busy", 64'(busy_seen), 64'd7);
        check("d_mul8_res", EXMEM_vALU_Out, 64'h100E_0C0A_0806_0402);
        check("d_mul8_v", 64'(EXMEM_valid), 64'd1);

        // vmul SEW=32 then vadd back to back; junk during MUL is ignored
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        valid_seen = 0;
        step(1'b1, 4'd7, 2'd2, 5'd5, 1'b1, ra, rb, 1'b0, 1'b0);
        step(1'b1, 4'd2, 2'd0, 5'd9, 1'b1, rb, ra, 1'b0, 1'b0);
        step(1'b1, 4'd7, 2'd2, 5'd5, 1'b1, ra, rb, 1'b0, 1'b0);
        check("d_b2b_mul", EXMEM_vALU_Out, ref_op(4'd7, 2'd2, ra, rb));
        step(1'b1, 4'd0, 2'd2, 5'd6, 1'b1, ra, rb, 1'b0, 1'b0);
        check("d_b2b_add", EXMEM_vALU_Out, ref_op(4'd0, 2'd2, ra, rb));
        idle(2);
        check("d_b2b_cnt", 64'(valid_seen), 64'd2);

        // Flush in the third MUL cycle of a SEW=8 vmul
        valid_seen = 0;
        step(1'b1, 4'd7, 2'd0, 5'd7, 1'b1, ra, rb, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 4'd0, 2'd0, 5'd0, 1'b0, '0, '0, 1'b1, 1'b0);
        check("d_flush_busy", 64'(vex_busy), 64'd0);
        idle(10);
        check("d_flush_cnt", 64'(valid_seen), 64'd0);

        // Reset during MUL, then an unassigned opcode with write enable
        step(1'b1, 4'd7, 2'd0, 5'd8, 1'b1, ra, rb, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 4'd0, 2'd0, 5'd0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("d_rst_res", EXMEM_vALU_Out, 64'h0);
        check("d_rst_vrd", 64'(EXMEM_instr_vrd), 64'd0);
        check("d_rst_busy", 64'(vex_busy), 64'd0);
        step(1'b1, 4'd9, 2'd1, 5'd5, 1'b1, ra, rb, 1'b0, 1'b0);
        check("d_op9_vwe", 64'(EXMEM_vRegWrite), 64'd0);
        check("d_op9_res", EXMEM_vALU_Out, 64'h0);
        check("d_op9_v", 64'(EXMEM_valid), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rop = ($urandom_range(0, 3) == 0) ? 4'd7 : 4'($urandom_range(0, 9));
            step($urandom_range(0, 3) != 0, rop, 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), ra, rb,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 200) == 0);
        end
        idle(10);
        check("q_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
